// File: rtl/celeste_pkg.sv
// Shared types for the celeste palette engine: colour word, fade FSM states
// and fade command encodings.
package celeste_pkg;

    localparam int unsigned PAL_CH_W = 4;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_FULL     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_DARK     = 2'd2,
        ST_FADE_IN  = 2'd3
    } fade_state_t;

    localparam logic [1:0] CMD_NONE     = 2'd0;
    localparam logic [1:0] CMD_FADE_OUT = 2'd1;
    localparam logic [1:0] CMD_FADE_IN  = 2'd2;
    localparam logic [1:0] CMD_RSVD     = 2'd3;

endpackage

// File: rtl/celeste_palette_ram.sv
// Simple dual-port palette store: one write port, one registered read-first
// read port. Contents are never reset.
module celeste_palette_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking update makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/celeste_palette_engine.sv
// Double-banked writable palette lookup with frame-synchronous fade to/from
// black. Two-cycle pixel pipeline: RAM read, then scale and register.
module celeste_palette_engine
    import celeste_pkg::*;
#(
    parameter int unsigned INDEX_W     = 8,
    parameter int unsigned CH_W        = PAL_CH_W,
    parameter int unsigned BANKS       = 2,
    parameter int unsigned FADE_W      = 4,
    parameter int unsigned FADE_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_W-1:0]    pix_index,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    output logic [CH_W-1:0]       red,
    output logic [CH_W-1:0]       green,
    output logic [CH_W-1:0]       blue,
    output logic                  out_valid,
    input  logic                  wr_en,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] wr_bank,
    input  logic [INDEX_W-1:0]    wr_addr,
    input  logic [3*CH_W-1:0]     wr_data,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] bank_req,
    input  logic                  bank_req_valid,
    output logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0] active_bank,
    input  logic [1:0]            fade_cmd,
    output logic [FADE_W:0]       fade_level,
    output logic                  fade_busy
);

    localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned ADDR_W = BANK_W + INDEX_W;
    localparam int unsigned RGB_W  = 3 * CH_W;
    localparam int unsigned LVL_W  = FADE_W + 1;
    localparam int unsigned PROD_W = CH_W + FADE_W + 1;
    localparam int unsigned CNT_W  = $clog2(FADE_PERIOD + 1);
    localparam int unsigned DEPTH  = BANKS * (2 ** INDEX_W);

    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(2 ** FADE_W);
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(BANKS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FADE_PERIOD);

    logic [BANK_W-1:0] pending_bank;
    logic [RGB_W-1:0]  rd_data;
    logic              valid_s1;

    fade_state_t       state, state_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic              busy_nxt;

    // Bank selection only moves on frame boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_bank <= '0;
            active_bank  <= '0;
        end else begin
            if (bank_req_valid) begin
                pending_bank <= bank_req;
            end
            if (frame_start) begin
                active_bank <= pending_bank;
            end
        end
    end

    celeste_palette_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RGB_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank & BANK_MASK, wr_addr}),
        .wr_data (wr_data),
        .rd_addr ({active_bank & BANK_MASK, pix_index}),
        .rd_data (rd_data)
    );

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [LVL_W-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(lvl);
        return CH_W'(prod >> FADE_W);
    endfunction

    // Stage 2: scale by the level current at this edge and register outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1  <= 1'b0;
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            valid_s1  <= pix_valid;
            out_valid <= valid_s1;
            red       <= scale(rd_data[RGB_W-1 -: CH_W], fade_level);
            green     <= scale(rd_data[2*CH_W-1 -: CH_W], fade_level);
            blue      <= scale(rd_data[CH_W-1:0], fade_level);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FULL;
            fade_level <= LVL_MAX;
            cnt        <= '0;
            fade_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fade_level <= level_nxt;
            cnt        <= cnt_nxt;
            fade_busy  <= busy_nxt;
        end
    end

    // Fade FSM: commands only accepted at the two rest levels.
    always_comb begin
        state_nxt = state;
        level_nxt = fade_level;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + CNT_W'(1);
        case (state)
            ST_FULL: begin
                if (fade_cmd == CMD_FADE_OUT) begin
                    state_nxt = ST_FADE_OUT;
                    cnt_nxt   = '0;
                end
            end
            ST_DARK: begin
                if (fade_cmd == CMD_FADE_IN) begin
                    state_nxt = ST_FADE_IN;
                    cnt_nxt   = '0;
                end
            end
            ST_FADE_OUT: begin
                if (frame_start) begin
                    if (cnt_inc == CNT_LAST) begin
                        cnt_nxt   = '0;
                        level_nxt = fade_level - LVL_W'(1);
                        if (level_nxt == '0) begin
                            state_nxt = ST_DARK;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            ST_FADE_IN: begin
                if (frame_start) begin
                    if (cnt_inc == CNT_LAST) begin
                        cnt_nxt   = '0;
                        level_nxt = fade_level + LVL_W'(1);
                        if (level_nxt == LVL_MAX) begin
                            state_nxt = ST_FULL;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_FULL;
                level_nxt = LVL_MAX;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = (state_nxt == ST_FADE_OUT) || (state_nxt == ST_FADE_IN);
    end

endmodule

// File: tb/tb_celeste_palette_engine.sv
// Directed, table-driven bench for celeste_palette_engine (default parameters).
module tb_celeste_palette_engine;
    import celeste_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pix_index;
    logic        pix_valid;
    logic        frame_start;
    logic [3:0]  red, green, blue;
    logic        out_valid;
    logic        wr_en;
    logic [0:0]  wr_bank;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic [0:0]  bank_req;
    logic        bank_req_valid;
    logic [0:0]  active_bank;
    logic [1:0]  fade_cmd;
    logic [4:0]  fade_level;
    logic        fade_busy;

    int n_cmp = 0;
    int n_err = 0;

    celeste_palette_engine dut (
        .clk            (clk),
        .reset          (reset),
        .pix_index      (pix_index),
        .pix_valid      (pix_valid),
        .frame_start    (frame_start),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .out_valid      (out_valid),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .bank_req       (bank_req),
        .bank_req_valid (bank_req_valid),
        .active_bank    (active_bank),
        .fade_cmd       (fade_cmd),
        .fade_level     (fade_level),
        .fade_busy      (fade_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] idx;
        rgb_t       data;
        rgb_t       exp;
    } pal_vec_t;

    typedef struct {
        int         frames;
        logic [4:0] exp_level;
        logic       exp_busy;
        rgb_t       exp_white;
        rgb_t       exp_mixed;
    } fade_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [0:0] bank, input logic [7:0] addr, input logic [11:0] data);
        wr_en = 1'b1; wr_bank = bank; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_pix(input logic [7:0] idx, output logic [11:0] rgb);
        pix_index = idx; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        check("valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'd1);
        rgb = {red, green, blue};
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    task automatic pulse_cmd(input logic [1:0] cmd, input logic with_frame);
        fade_cmd = cmd; frame_start = with_frame;
        @(negedge clk);
        fade_cmd = CMD_NONE; frame_start = 1'b0;
    endtask

    task automatic pulse_req(input logic [0:0] b);
        bank_req = b; bank_req_valid = 1'b1;
        @(negedge clk);
        bank_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pal_vec_t   pal [5];
        fade_vec_t  fv  [5];
        logic [11:0] rgb;

        pal[0] = '{8'h05, 12'hF04, 12'hF04};
        pal[1] = '{8'h10, 12'hFFF, 12'hFFF};
        pal[2] = '{8'h20, 12'h8C3, 12'h8C3};
        pal[3] = '{8'hFF, 12'h5A5, 12'h5A5};
        pal[4] = '{8'h00, 12'h1E7, 12'h1E7};

        // level 14 (entry at counter 0), then 8, 1, still 1, and finally 0
        fv[0] = '{0,  5'd14, 1'b1, 12'hDDD, 12'h7A2};
        fv[1] = '{24, 5'd8,  1'b1, 12'h777, 12'h461};
        fv[2] = '{28, 5'd1,  1'b1, 12'h000, 12'h000};
        fv[3] = '{3,  5'd1,  1'b1, 12'h000, 12'h000};
        fv[4] = '{1,  5'd0,  1'b0, 12'h000, 12'h000};

        reset = 1'b1; pix_index = 8'h05; pix_valid = 1'b1; frame_start = 1'b0;
        wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        bank_req = '0; bank_req_valid = 1'b0; fade_cmd = CMD_NONE;
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'({red, green, blue}), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(fade_level), 32'd16);
        check("rst_busy", 32'(fade_busy), 32'd0);
        check("rst_bank", 32'(active_bank), 32'd0);
        reset = 1'b0; pix_valid = 1'b0;
        repeat (2) @(negedge clk);

        foreach (pal[i]) wr(1'b0, pal[i].idx, pal[i].data);
        wr(1'b0, 8'h07, 12'h111);
        foreach (pal[i]) begin
            read_pix(pal[i].idx, rgb);
            check($sformatf("pal_read_%0h", pal[i].idx), 32'(rgb), 32'(pal[i].exp));
        end

        // bank switch waits for frame_start
        wr(1'b1, 8'h05, 12'h123);
        pulse_req(1'b1);
        read_pix(8'h05, rgb);
        check("bank_pre_switch", 32'(rgb), 32'hF04);
        check("active_pre", 32'(active_bank), 32'd0);
        frames(1);
        check("active_post", 32'(active_bank), 32'd1);
        read_pix(8'h05, rgb);
        check("bank_post_switch", 32'(rgb), 32'h123);
        pulse_req(1'b1);
        pulse_req(1'b0);
        frames(1);
        check("last_req_wins", 32'(active_bank), 32'd0);
        read_pix(8'h05, rgb);
        check("bank0_again", 32'(rgb), 32'hF04);

        // read-first collision
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 8'h07; wr_data = 12'hABC;
        pix_index = 8'h07; pix_valid = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        check("collide_old", 32'({red, green, blue}), 32'h111);
        read_pix(8'h07, rgb);
        check("collide_new", 32'(rgb), 32'hABC);

        // fade commands
        pulse_cmd(CMD_FADE_IN, 1'b0);
        check("ign_in_level", 32'(fade_level), 32'd16);
        check("ign_in_busy", 32'(fade_busy), 32'd0);
        pulse_cmd(CMD_FADE_OUT, 1'b1);
        check("fo_busy", 32'(fade_busy), 32'd1);
        check("fo_level0", 32'(fade_level), 32'd16);
        frames(3);
        check("fo_3frames", 32'(fade_level), 32'd16);
        frames(1);
        check("fo_step1", 32'(fade_level), 32'd15);
        read_pix(8'h10, rgb);
        check("fo_white15", 32'(rgb), 32'hEEE);
        read_pix(8'h20, rgb);
        check("fo_mixed15", 32'(rgb), 32'h7B2);
        frames(2);
        pulse_cmd(CMD_FADE_OUT, 1'b0);
        check("ign_out_level", 32'(fade_level), 32'd15);
        frames(2);
        foreach (fv[i]) begin
            frames(fv[i].frames);
            check($sformatf("fade_level_%0d", i), 32'(fade_level), 32'(fv[i].exp_level));
            check($sformatf("fade_busy_%0d", i), 32'(fade_busy), 32'(fv[i].exp_busy));
            read_pix(8'h10, rgb);
            check($sformatf("fade_white_%0d", i), 32'(rgb), 32'(fv[i].exp_white));
            read_pix(8'h20, rgb);
            check($sformatf("fade_mixed_%0d", i), 32'(rgb), 32'(fv[i].exp_mixed));
        end

        // fade in to level 7, then reset mid-fade
        pulse_cmd(CMD_FADE_IN, 1'b0);
        check("fi_busy", 32'(fade_busy), 32'd1);
        frames(28);
        check("fi_level7", 32'(fade_level), 32'd7);
        read_pix(8'h10, rgb);
        check("fi_white7", 32'(rgb), 32'h666);
        pulse_req(1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_level", 32'(fade_level), 32'd16);
        check("rst2_busy", 32'(fade_busy), 32'd0);
        check("rst2_bank", 32'(active_bank), 32'd0);
        frames(1);
        check("rst2_pending_cleared", 32'(active_bank), 32'd0);
        read_pix(8'h05, rgb);
        check("rst2_pal5", 32'(rgb), 32'hF04);
        read_pix(8'h20, rgb);
        check("rst2_pal20", 32'(rgb), 32'h8C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
